// File: rtl/ins_ram_loader_pkg.sv
// Shared details for the instruction RAM path:
// init mode and loader FSM states.
package ins_ram_loader_pkg;

   typedef enum logic [1:0] {
      MEM_INIT_NONE,
      MEM_INIT_ZERO,
      MEM_INIT_FILE
   } mem_init_t;

   typedef enum logic [1:0] {
      IDLE,
      LEN,
      DATA,
      CHK
   } loader_state_t;

endpackage

// File: rtl/ins_ram_loader.sv
// Loads a framed word stream (length, program, checksum)
// from the UART receiver into the instruction RAM.
module ins_ram_loader
   import ins_ram_loader_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 256,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  rx_valid,
   input  logic [WIDTH-1:0]      rx_data,
   output logic                  ram_wrEn,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [WIDTH-1:0]      ram_dataIn,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   loader_state_t state_q, state_d;

   // One extra bit so a length of DEPTH is representable.
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic [ADDR_WIDTH:0]   len_q, len_d;
   logic [WIDTH-1:0]      sum_q, sum_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]      data_q, data_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic [31:0]           len_word;
   logic [WIDTH-1:0]      sum_nx;
   logic [ADDR_WIDTH:0]   cnt_nx;

   always_comb begin
      len_word = 32'(rx_data);
      if (rx_data == '0) len_word = 32'(DEPTH);
      sum_nx = sum_q + rx_data;
      cnt_nx = cnt_q + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      sum_d   = sum_q;
      wr_en_d = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LEN;
               busy_d  = 1'b1;
               cnt_d   = '0;
               sum_d   = '0;
            end
         end
         LEN: begin
            if (rx_valid) begin
               if (len_word > 32'(DEPTH)) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  err_d   = 1'b1;
               end else begin
                  state_d = DATA;
                  len_d   = len_word[ADDR_WIDTH:0];
               end
            end
         end
         DATA: begin
            if (rx_valid) begin
               wr_en_d = 1'b1;
               addr_d  = cnt_q[ADDR_WIDTH-1:0];
               data_d  = rx_data;
               cnt_d   = cnt_nx;
               sum_d   = sum_nx;
               if (cnt_nx == len_q) state_d = CHK;
            end
         end
         CHK: begin
            if (rx_valid) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               if (sum_nx == '0) done_d = 1'b1;
               else              err_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         sum_q   <= '0;
         wr_en_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         sum_q   <= sum_d;
         wr_en_q <= wr_en_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign ram_wrEn   = wr_en_q;
   assign ram_addr   = addr_q;
   assign ram_dataIn = data_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_ins_ram_loader.sv
// Directed table plus hand sequences for ins_ram_loader,
// one instance at DEPTH=256 and one at DEPTH=16.
module tb_ins_ram_loader;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, rxv;
   logic [7:0] rxd;
   logic       wr, busy, done, err;
   logic [7:0] addr, data;

   logic       b_rst, b_start, b_rxv;
   logic [7:0] b_rxd;
   logic       b_wr, b_busy, b_done, b_err;
   logic [3:0] b_addr;
   logic [7:0] b_data;

   int n_vec = 0;
   int n_bad = 0;
   int b_wr_cnt = 0;

   ins_ram_loader #(.WIDTH(8), .DEPTH(256)) dut_a (
      .clk(clk), .rst(rst), .start(start),
      .rx_valid(rxv), .rx_data(rxd),
      .ram_wrEn(wr), .ram_addr(addr), .ram_dataIn(data),
      .busy(busy), .done(done), .err(err)
   );

   ins_ram_loader #(.WIDTH(8), .DEPTH(16)) dut_b (
      .clk(clk), .rst(b_rst), .start(b_start),
      .rx_valid(b_rxv), .rx_data(b_rxd),
      .ram_wrEn(b_wr), .ram_addr(b_addr), .ram_dataIn(b_data),
      .busy(b_busy), .done(b_done), .err(b_err)
   );

   always @(posedge clk) if (b_wr) b_wr_cnt <= b_wr_cnt + 1;

   typedef struct {
      logic       rst, start, rxv;
      logic [7:0] rxd;
      logic       wr;
      logic [7:0] addr, data;
      logic       busy, done, err;
   } vec_t;

   function automatic vec_t mk(logic r, logic s, logic v,
                               logic [7:0] d, logic w,
                               logic [7:0] a, logic [7:0] dt,
                               logic b, logic dn, logic e);
      vec_t t;
      t.rst = r; t.start = s; t.rxv = v; t.rxd = d;
      t.wr = w; t.addr = a; t.data = dt;
      t.busy = b; t.done = dn; t.err = e;
      return t;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   vec_t tbl [28];

   initial begin
      rst = 1'b1; start = 1'b0; rxv = 1'b0; rxd = '0;
      b_rst = 1'b1; b_start = 1'b0; b_rxv = 1'b0; b_rxd = '0;

      //            rst st v  rxd    wr addr  data  bsy dn er
      tbl[0]  = mk(1, 0, 0, 8'h00, 0, 8'd0, 8'h00, 0, 0, 0);
      tbl[1]  = mk(0, 1, 0, 8'h00, 0, 8'd0, 8'h00, 1, 0, 0);
      tbl[2]  = mk(0, 0, 1, 8'h03, 0, 8'd0, 8'h00, 1, 0, 0);
      tbl[3]  = mk(0, 0, 1, 8'h11, 1, 8'd0, 8'h11, 1, 0, 0);
      tbl[4]  = mk(0, 0, 1, 8'h22, 1, 8'd1, 8'h22, 1, 0, 0);
      tbl[5]  = mk(0, 1, 0, 8'h00, 0, 8'd1, 8'h22, 1, 0, 0);
      tbl[6]  = mk(0, 0, 1, 8'h33, 1, 8'd2, 8'h33, 1, 0, 0);
      tbl[7]  = mk(0, 0, 1, 8'h9A, 0, 8'd2, 8'h33, 0, 1, 0);
      tbl[8]  = mk(0, 0, 0, 8'h00, 0, 8'd2, 8'h33, 0, 0, 0);
      tbl[9]  = mk(0, 0, 1, 8'h55, 0, 8'd2, 8'h33, 0, 0, 0);
      tbl[10] = mk(0, 1, 1, 8'h03, 0, 8'd2, 8'h33, 1, 0, 0);
      tbl[11] = mk(0, 0, 1, 8'h03, 0, 8'd2, 8'h33, 1, 0, 0);
      tbl[12] = mk(0, 0, 1, 8'h11, 1, 8'd0, 8'h11, 1, 0, 0);
      tbl[13] = mk(0, 0, 1, 8'h22, 1, 8'd1, 8'h22, 1, 0, 0);
      tbl[14] = mk(0, 0, 1, 8'h33, 1, 8'd2, 8'h33, 1, 0, 0);
      tbl[15] = mk(0, 0, 1, 8'h9B, 0, 8'd2, 8'h33, 0, 0, 1);
      tbl[16] = mk(0, 0, 0, 8'h00, 0, 8'd2, 8'h33, 0, 0, 0);
      tbl[17] = mk(0, 1, 0, 8'h00, 0, 8'd2, 8'h33, 1, 0, 0);
      tbl[18] = mk(0, 0, 1, 8'h05, 0, 8'd2, 8'h33, 1, 0, 0);
      tbl[19] = mk(0, 0, 1, 8'hA0, 1, 8'd0, 8'hA0, 1, 0, 0);
      tbl[20] = mk(0, 0, 1, 8'hA1, 1, 8'd1, 8'hA1, 1, 0, 0);
      tbl[21] = mk(1, 0, 1, 8'hA2, 0, 8'd0, 8'h00, 0, 0, 0);
      tbl[22] = mk(0, 0, 1, 8'hA3, 0, 8'd0, 8'h00, 0, 0, 0);
      tbl[23] = mk(0, 1, 0, 8'h00, 0, 8'd0, 8'h00, 1, 0, 0);
      tbl[24] = mk(0, 0, 1, 8'h02, 0, 8'd0, 8'h00, 1, 0, 0);
      tbl[25] = mk(0, 0, 1, 8'h40, 1, 8'd0, 8'h40, 1, 0, 0);
      tbl[26] = mk(0, 0, 1, 8'h41, 1, 8'd1, 8'h41, 1, 0, 0);
      tbl[27] = mk(0, 0, 1, 8'h7F, 0, 8'd1, 8'h41, 0, 1, 0);

      for (int i = 0; i < 28; i++) begin
         rst = tbl[i].rst; start = tbl[i].start;
         rxv = tbl[i].rxv; rxd = tbl[i].rxd;
         step();
         check($sformatf("vec%0d ctl", i),
               {27'd0, wr, busy, done, err, 1'b0} | {16'd0, addr, 8'd0},
               {27'd0, tbl[i].wr, tbl[i].busy, tbl[i].done,
                tbl[i].err, 1'b0} | {16'd0, tbl[i].addr, 8'd0});
         if (tbl[i].wr)
            check($sformatf("vec%0d data", i), 32'(data), 32'(tbl[i].data));
      end
      rst = 1'b0; start = 1'b0; rxv = 1'b0;

      // Full-depth frame: L=0 means 256 words, back to back.
      start = 1'b1; step(); start = 1'b0;
      rxv = 1'b1; rxd = 8'h00; step();
      for (int i = 0; i < 256; i++) begin
         rxd = 8'(i);
         step();
         check($sformatf("full wr%0d", i),
               {22'd0, wr, addr, done, err},
               {22'd0, 1'b1, 8'(i), 1'b0, 1'b0});
         check($sformatf("full dat%0d", i), 32'(data), i);
      end
      rxd = 8'h80; step(); rxv = 1'b0;
      check("full end", {28'd0, wr, busy, done, err}, 32'b0010);
      step();
      check("full after", {28'd0, wr, busy, done, err}, 32'b0000);

      // DEPTH=16 instance: oversize length is rejected.
      b_rst = 1'b1; step(); b_rst = 1'b0;
      b_start = 1'b1; step(); b_start = 1'b0;
      check("b busy", 32'(b_busy), 32'd1);
      b_rxv = 1'b1; b_rxd = 8'd17; step(); b_rxv = 1'b0;
      check("b bad len", {29'd0, b_busy, b_done, b_err}, 32'b001);
      step();
      check("b err pulse", {29'd0, b_busy, b_done, b_err}, 32'b000);
      b_rxv = 1'b1; b_rxd = 8'h12; step(); b_rxv = 1'b0;
      step();
      check("b no writes", b_wr_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/ins_ram_loader.md
# ins_ram_loader

Upstream writer for the instruction RAM. Takes a framed word stream (length word, program words, checksum word) from the UART receiver and writes the program words into the instruction RAM at consecutive addresses starting from 0. While loading it drives the RAM write port directly. When loading ends it reports completion or a framing/checksum error so the core controller can release the processors from reset.

## Interface
Parameters:
- WIDTH, 8, data word width; must match the instruction RAM WIDTH
- DEPTH, 256, instruction RAM depth in words
- ADDR_WIDTH, $clog2(DEPTH), RAM address width

Ports:
- clk  input  1  single clock
- rst  input  1  reset; synchronous, active-high
- start  input  1  one-cycle request to begin a load; ignored unless in IDLE
- rx_valid  input  1  one-cycle strobe: rx_data holds a new received word
- rx_data  input  WIDTH  received word
- ram_wrEn  output  1  write enable to instruction RAM
- ram_addr  output  ADDR_WIDTH  RAM address
- ram_dataIn  output  WIDTH  RAM write data
- busy  output  1  high from accepted start until done/err
- done  output  1  one-cycle pulse: load finished, checksum matched
- err  output  1  one-cycle pulse: load aborted (bad length or checksum mismatch)

## Operation
- No backpressure. Every rx_valid seen in LEN, DATA or CHK is consumed. rx_valid in IDLE is dropped.
- FSM in loader_state_t: IDLE, LEN, DATA, CHK.
- IDLE: on start, go to LEN, set busy, clear word counter and running sum.
- LEN: the first word is the program length L.
  - L = 0 means DEPTH.
  - L > DEPTH means pulse err, go to IDLE.
  - Otherwise latch L and go to DATA.
- DATA: each received word is written to address cnt, then cnt increments. Running sum = (sum + word) mod 2^WIDTH. After word L, go to CHK.
- CHK: next word C.
  - If (sum + C) mod 2^WIDTH == 0, pulse done.
  - Otherwise pulse err.
  - Return to IDLE in either case.
- The counter is ADDR_WIDTH+1 bits so that L = DEPTH terminates correctly. ram_addr is its low ADDR_WIDTH bits; the last write goes to DEPTH-1.
- Words already written before an err stay in RAM; no rollback.
- start while busy: ignored.
- start and rx_valid in the same IDLE cycle: start is taken, the rx word is dropped.
- Reset mid-load: next cycle FSM is IDLE and all outputs are at reset values. Any RAM write in progress that cycle is suppressed.

## Timing
- All outputs registered.
- Reset values: ram_wrEn=0, ram_addr=0, ram_dataIn=0, busy=0, done=0, err=0.
- rx_valid in DATA at cycle t: ram_wrEn=1 with ram_addr/ram_dataIn valid at t+1, for exactly one cycle. The RAM captures the word on the edge ending t+1.
- ram_addr holds its last value between writes.
- start at t: busy=1 from t+1.
- Checksum word at t: done or err high at t+1 only; busy=0 from t+1.
- Bad length word at t: err at t+1, busy=0 at t+1, no write ever issued.
- Back-to-back rx_valid (every cycle) is supported at full rate.

## Structure
- loader_state_t enum goes in the shared details package next to mem_init_t.
- Single module; counter and checksum are inline. No sub-module needed.
- Top level muxes the RAM port: loader drives it while busy, the core fetch path drives it otherwise.

## Test plan
- start, then words 3, 0x11, 0x22, 0x33, 0x9A -> writes 0x11@0, 0x22@1, 0x33@2; sum 0x66 + 0x9A = 0x00, so done pulse, busy falls the same cycle.
- Same frame with checksum 0x9B -> same three writes, then err pulse and no done.
- DEPTH=256, L=0, then 256 words i -> last write at addr 255; correct checksum gives done; counter does not wrap early.
- DEPTH=16, L=17 -> err one cycle after the length word, zero ram_wrEn pulses.
- rst asserted after the 2nd of 5 data words -> next cycle busy=0 and ram_wrEn=0; a later rx_valid writes nothing; a new start loads correctly from addr 0.
- rx_valid while IDLE, and start while busy -> no writes and no state change from either; the load in progress completes unaffected.
